btn_debounce_pulse: RTL and testbench
=====================================

# btn_debounce_pulse

Upstream conditioning stage for the processor's step button. Takes a raw, bouncing, asynchronous push-button input, synchronizes it, filters it with a stable-count state machine, and emits a one-clock `pulse` per accepted press. That pulse drives the program counter's increment enable. An optional auto-repeat generates further pulses while the button is held.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1_000_000: consecutive agreeing samples needed to accept a press or release (10 ms at 100 MHz); must be ≥ 1.
- `REPEAT_EN`, default 0: 1 enables auto-repeat pulses while held.
- `REPEAT_DELAY`, default 50_000_000: cycles from the first pulse to the first repeat pulse; must be ≥ 1.
- `REPEAT_PERIOD`, default 20_000_000: cycles between subsequent repeat pulses; must be ≥ 1.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `btn_in`, in, 1: raw button, asynchronous to `clk`, high = pressed.
- `pulse`, out, 1: one-cycle strobe per accepted press or repeat; feeds the PC increment enable.
- `level`, out, 1: debounced button state.
- `release_pulse`, out, 1: one-cycle strobe per accepted release.

## Operation
- `btn_in` passes through a 2-FF synchronizer to produce `btn_s`. The FSM and counters use only `btn_s`.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- **IDLE**, `level`=0:
  - `btn_s`=1 → PRESS_WAIT, with `stab_cnt`=1.
- **PRESS_WAIT**:
  - `btn_s`=0 → IDLE, `stab_cnt`=0.
  - Otherwise `stab_cnt` increments.
  - When the sample that makes STABLE_CYCLES consecutive highs arrives → PRESSED. `pulse`=1 and `level`=1 in the following cycle. `rep_cnt` is cleared.
- **PRESSED**, `level`=1:
  - `btn_s`=0 → RELEASE_WAIT, `stab_cnt`=1. No repeat pulse is issued on that edge.
  - Otherwise, if REPEAT_EN, `rep_cnt` increments. On reaching REPEAT_DELAY (first repeat) or REPEAT_PERIOD (later repeats): `pulse`=1 for one cycle and `rep_cnt` clears.
- **RELEASE_WAIT**, `level` stays 1:
  - `btn_s`=1 → PRESSED. No new pulse; `rep_cnt` holds its value.
  - STABLE_CYCLES consecutive lows → IDLE. `level`=0 and `release_pulse`=1 in the following cycle.
- Bounce shorter than STABLE_CYCLES never produces `pulse` or `release_pulse`.
- All outputs are registered. `pulse` and `release_pulse` are never both high.
- Counter width is `$clog2(max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1)`. Counters saturate and never wrap.

## Timing
- Reset values: `pulse`=0, `level`=0, `release_pulse`=0, state IDLE, all counters 0, synchronizer flops 0.
- `rst` asserted mid-operation returns to reset values immediately.
- If the button is held across reset release, it is treated as a fresh press: `pulse` fires after the normal latency.
- Press latency: `btn_in` high and stable before clock edge E1 → `btn_s` high after E2 → `pulse` high for the single cycle after edge E(2+STABLE_CYCLES).
- Release latency is the same, measured to `release_pulse` and to `level` falling.
- First repeat: `pulse` goes high REPEAT_DELAY+1 cycles after the first `pulse` cycle, counted cycle-accurately while `btn_s` stays high.
- Later repeats: every REPEAT_PERIOD+1 cycles thereafter.
- Throughput: at most one `pulse` per cycle; pulses are always separated by ≥ 1 low cycle.

## Structure
- Shared package `sp_pkg` holds:
  - `typedef enum logic [1:0] {DB_IDLE, DB_PRESS_WAIT, DB_PRESSED, DB_RELEASE_WAIT} db_state_t`.
  - A `CLK_HZ` constant (100_000_000) used to derive parameter defaults.
- Sub-module `sync_2ff` (1-bit, async reset to 0) provides the synchronizer and is reused by other button inputs.
- The top-level debouncer contains the FSM, `stab_cnt`, `rep_cnt` and the output registers.

## Test plan
Bench parameters: STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press: hold `btn_in`=1 from edge 1 → `pulse` high only in the cycle after edge 6, and `level` rises at the same point. Releasing at edge 20 → `release_pulse` high only in the cycle after edge 25.
- Bounce: toggle `btn_in` 1,1,0,1,1,1,0 on consecutive cycles, then 0 → no `pulse`, `level` stays 0.
- Release bounce: while pressed, drop `btn_s` low for 2 cycles then high again → state returns to PRESSED, no `pulse` and no `release_pulse`, `level` stays 1 throughout.
- Auto-repeat with REPEAT_EN=1, holding 40 cycles → pulses at the first-pulse cycle +11, then every +6. Exactly one pulse per event. No repeat pulse on the edge the release starts.
- REPEAT_EN=0, hold 100 cycles → exactly one `pulse`.
- Reset mid-operation: assert `rst` during PRESS_WAIT and during PRESSED → all outputs 0 at once. With `btn_in` still high after `rst` drops → `pulse` fires 6 edges later.

Source files
------------

// File: rtl/sp_pkg.sv
// sp_pkg: shared types and constants for the front-panel button conditioning blocks.
// Rev 1.0
`default_nettype none

package sp_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_RELEASE_WAIT
  } db_state_t;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Defaults: 10 ms debounce, 500 ms to first repeat, 200 ms between repeats.
  localparam int unsigned DB_STABLE_DEFAULT = CLK_HZ / 100;
  localparam int unsigned DB_REP_DELAY_DEFAULT = CLK_HZ / 2;
  localparam int unsigned DB_REP_PERIOD_DEFAULT = CLK_HZ / 5;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer, asynchronous active-high reset to 0.
// Rev 1.0
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronizes and debounces the step button, emitting one-cycle
// press/release strobes and optional auto-repeat pulses while held. Rev 1.0
`default_nettype none

module btn_debounce_pulse
  import sp_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DB_STABLE_DEFAULT,
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = DB_REP_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD = DB_REP_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic level,
  output logic release_pulse
);

  localparam int unsigned CNT_TOP = max3(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int          CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_C     = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C    = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic btn_s;

  db_state_t        state, state_n;
  logic [CNT_W-1:0] stab_cnt, stab_n;
  logic [CNT_W-1:0] rep_cnt, rep_n;
  logic             rep_first, rep_first_n;
  logic             pulse_n, level_n, release_n;
  logic [CNT_W-1:0] rep_target;
  logic [CNT_W-1:0] stab_inc, rep_inc;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= DB_IDLE;
      stab_cnt      <= '0;
      rep_cnt       <= '0;
      rep_first     <= 1'b0;
      pulse         <= 1'b0;
      level         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      stab_cnt      <= stab_n;
      rep_cnt       <= rep_n;
      rep_first     <= rep_first_n;
      pulse         <= pulse_n;
      level         <= level_n;
      release_pulse <= release_n;
    end
  end

  // Saturating increments so a long hold can never wrap a counter.
  assign stab_inc   = (stab_cnt == CNT_SAT) ? stab_cnt : stab_cnt + CNT_ONE;
  assign rep_inc    = (rep_cnt == CNT_SAT) ? rep_cnt : rep_cnt + CNT_ONE;
  assign rep_target = rep_first ? DELAY_C : PERIOD_C;

  always_comb begin
    state_n     = state;
    stab_n      = stab_cnt;
    rep_n       = rep_cnt;
    rep_first_n = rep_first;
    pulse_n     = 1'b0;
    release_n   = 1'b0;
    level_n     = level;

    case (state)
      DB_IDLE: begin
        if (btn_s) begin
          if (STABLE_CYCLES == 1) begin
            state_n     = DB_PRESSED;
            stab_n      = '0;
            rep_n       = '0;
            rep_first_n = 1'b1;
            pulse_n     = 1'b1;
            level_n     = 1'b1;
          end else begin
            state_n = DB_PRESS_WAIT;
            stab_n  = CNT_ONE;
          end
        end
      end

      DB_PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = DB_IDLE;
          stab_n  = '0;
        end else if (stab_cnt >= STABLE_LAST) begin
          state_n     = DB_PRESSED;
          stab_n      = '0;
          rep_n       = '0;
          rep_first_n = 1'b1;
          pulse_n     = 1'b1;
          level_n     = 1'b1;
        end else begin
          stab_n = stab_inc;
        end
      end

      DB_PRESSED: begin
        // A falling sample takes priority so no repeat fires on the release edge.
        if (!btn_s) begin
          if (STABLE_CYCLES == 1) begin
            state_n   = DB_IDLE;
            stab_n    = '0;
            level_n   = 1'b0;
            release_n = 1'b1;
          end else begin
            state_n = DB_RELEASE_WAIT;
            stab_n  = CNT_ONE;
          end
        end else if (REPEAT_EN) begin
          if (rep_cnt >= rep_target) begin
            pulse_n     = 1'b1;
            rep_n       = '0;
            rep_first_n = 1'b0;
          end else begin
            rep_n = rep_inc;
          end
        end
      end

      DB_RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = DB_PRESSED;
          stab_n  = '0;
        end else if (stab_cnt >= STABLE_LAST) begin
          state_n   = DB_IDLE;
          stab_n    = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          stab_n = stab_inc;
        end
      end

      default: begin
        state_n = DB_IDLE;
        stab_n  = '0;
        level_n = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: directed stimulus against a run-length model of the debouncer,
// with two instances (auto-repeat on / off) sharing the same button.
`default_nettype none

module tb_btn_debounce_pulse;

  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic pulse_a, level_a, rel_a;
  logic pulse_b, level_b, rel_b;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .STABLE_CYCLES(SC), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_rep (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .pulse(pulse_a), .level(level_a), .release_pulse(rel_a)
  );

  btn_debounce_pulse #(
    .STABLE_CYCLES(SC), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_one (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .pulse(pulse_b), .level(level_b), .release_pulse(rel_b)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: level flips once SC consecutive synchronized samples disagree with it.
  // Repeats count held-high samples that follow a high sample while the level is up.
  bit m_s1, m_s2, m_prev;
  bit m_lvl[2], m_first[2], m_pulse[2], m_rel[2];
  int m_run[2], m_rep[2];
  bit m_ren[2] = '{1'b1, 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0;
      for (int i = 0; i < 2; i++) begin
        m_lvl[i] = 0; m_first[i] = 0; m_pulse[i] = 0; m_rel[i] = 0;
        m_run[i] = 0; m_rep[i] = 0;
      end
    end else begin
      bit smp;
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_in;
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 0;
        m_rel[i]   = 0;
        if (smp != m_lvl[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == SC) begin
          m_lvl[i] = smp;
          m_run[i] = 0;
          if (smp) begin
            m_pulse[i] = 1; m_rep[i] = 0; m_first[i] = 1;
          end else begin
            m_rel[i] = 1;
          end
        end else if (m_ren[i] && m_lvl[i] && smp && m_prev) begin
          m_rep[i]++;
          if (m_rep[i] == (m_first[i] ? RD + 1 : RP + 1)) begin
            m_pulse[i] = 1; m_rep[i] = 0; m_first[i] = 0;
          end
        end
      end
      m_prev = smp;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      check("model pulse rep", pulse_a, m_pulse[0]);
      check("model level rep", level_a, m_lvl[0]);
      check("model release rep", rel_a, m_rel[0]);
      check("model pulse one", pulse_b, m_pulse[1]);
      check("model level one", level_b, m_lvl[1]);
      check("model release one", rel_b, m_rel[1]);
    end
  end

  // Window recorder: drv[k-1] is btn_in before edge k; k indexes edges of the window.
  bit drv[$];
  int pk_a[$], pk_b[$], rk_a[$], rk_b[$], lv_b[$];

  function automatic int qat(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic set_drv(input int highs_from, input int highs_to, input int len);
    drv.delete();
    for (int k = 1; k <= len; k++) drv.push_back((k >= highs_from && k <= highs_to) ? 1'b1 : 1'b0);
  endtask

  task automatic run_window(input int n);
    pk_a.delete(); pk_b.delete(); rk_a.delete(); rk_b.delete(); lv_b.delete();
    btn_in = drv[0];
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (pulse_a) pk_a.push_back(k);
      if (pulse_b) pk_b.push_back(k);
      if (rel_a) rk_a.push_back(k);
      if (rel_b) rk_b.push_back(k);
      lv_b.push_back(int'(level_b));
      btn_in = (k < drv.size()) ? drv[k] : drv[drv.size()-1];
    end
  endtask

  function automatic int count_high(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  initial begin
    int exp_rep[6];
    exp_rep = '{6, 17, 23, 29, 35, 41};
    rst = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pulse rep", pulse_a, 0);
    check("reset level rep", level_a, 0);
    check("reset release rep", rel_a, 0);
    check("reset pulse one", pulse_b, 0);
    check("reset level one", level_b, 0);
    check("reset release one", rel_b, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Clean press held edges 1..19, released before edge 20.
    set_drv(1, 19, 20);
    run_window(32);
    check("clean press count", pk_b.size(), 1);
    check("clean press edge", qat(pk_b, 0), 6);
    check("clean level before", lv_b[4], 0);
    check("clean level at pulse", lv_b[5], 1);
    check("clean release count", rk_b.size(), 1);
    check("clean release edge", qat(rk_b, 0), 25);
    check("clean level before release", lv_b[23], 1);
    check("clean level after release", lv_b[24], 0);
    check("clean rep count", pk_a.size(), 2);
    check("clean rep first repeat", qat(pk_a, 1), 17);
    check("clean rep release edge", qat(rk_a, 0), 25);

    // Bounce: 1,1,0,1,1,1,0 then low.
    drv.delete();
    drv = '{1, 1, 0, 1, 1, 1, 0, 0};
    run_window(16);
    check("bounce pulses rep", pk_a.size(), 0);
    check("bounce pulses one", pk_b.size(), 0);
    check("bounce level", count_high(lv_b), 0);

    // Release bounce: high 1..10, low 11..12, high 13..20, then released.
    drv.delete();
    for (int k = 1; k <= 22; k++) drv.push_back((k <= 10 || (k >= 13 && k <= 20)) ? 1'b1 : 1'b0);
    run_window(35);
    check("rel bounce pulses one", pk_b.size(), 1);
    check("rel bounce release count", rk_b.size(), 1);
    check("rel bounce release edge", qat(rk_b, 0), 26);
    check("rel bounce level cycles", count_high(lv_b), 20);
    check("rel bounce repeat after pause", qat(pk_a, 1), 20);

    // Auto-repeat: held edges 1..44 so the would-be repeat lands on the release edge.
    set_drv(1, 44, 46);
    run_window(60);
    check("repeat count", pk_a.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("repeat pulse %0d", i), qat(pk_a, i), exp_rep[i]);
    check("repeat release edge", qat(rk_a, 0), 50);
    check("norepeat count", pk_b.size(), 1);

    // Long hold without repeat.
    set_drv(1, 100, 101);
    run_window(115);
    check("hold100 pulses one", pk_b.size(), 1);
    check("hold100 release one", qat(rk_b, 0), 106);

    // Reset during PRESS_WAIT.
    set_drv(1, 200, 200);
    run_window(4);
    rst = 1'b1;
    #1;
    check("rst pw level", level_a, 0);
    check("rst pw pulse", pulse_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset during PRESSED, while the press strobe is high.
    run_window(6);
    check("pre-rst pulse", pulse_b, 1);
    rst = 1'b1;
    #1;
    check("rst pressed pulse rep", pulse_a, 0);
    check("rst pressed level rep", level_a, 0);
    check("rst pressed pulse one", pulse_b, 0);
    check("rst pressed level one", level_b, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_window(12);
    check("post-rst pulse one", qat(pk_b, 0), 6);
    check("post-rst pulse rep", qat(pk_a, 0), 6);

    set_drv(2, 1, 2);
    run_window(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
